// File: rtl/calendar_pkg.sv
// Shared calendar/clock definitions: BCD digit type, screen and cursor codes,
// and BCD digit/field arithmetic helpers.
package calendar_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned MAX_W      = 4 * MAX_DIGITS;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [1:0] SCREEN_TIME  = 2'd0;
    localparam logic [1:0] SCREEN_DATE  = 2'd1;
    localparam logic [1:0] SCREEN_ALARM = 2'd2;
    localparam logic [1:0] SCREEN_SETUP = 2'd3;

    localparam logic [2:0] EDIT_POS_0 = 3'd0;
    localparam logic [2:0] EDIT_POS_1 = 3'd1;
    localparam logic [2:0] EDIT_POS_2 = 3'd2;
    localparam logic [2:0] EDIT_POS_3 = 3'd3;
    localparam logic [2:0] EDIT_POS_4 = 3'd4;
    localparam logic [2:0] EDIT_POS_5 = 3'd5;
    localparam logic [2:0] EDIT_POS_6 = 3'd6;
    localparam logic [2:0] EDIT_POS_7 = 3'd7;

    function automatic bcd_digit_t digit_inc(input bcd_digit_t d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic bcd_digit_t digit_dec(input bcd_digit_t d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    // Increment the low ndig digits of v with decimal carry; upper digits untouched.
    function automatic logic [MAX_W-1:0] bcd_inc(input logic [MAX_W-1:0] v,
                                                 input int unsigned     ndig);
        logic [MAX_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
            if (carry && (k < ndig)) begin
                if (v[4*k +: 4] >= 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Active-low key press detector: one-cycle pulse on the falling edge of a
// debounced key level, suppressed for a key already held when reset releases.
module key_edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic key_n_i,
    output logic press_o
);

    logic prev_q;
    logic armed_q;

    // armed_q stays low until the key has been seen released, so a key held
    // through reset release cannot produce a press.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q  <= 1'b1;
            armed_q <= key_n_i;
        end else begin
            prev_q  <= key_n_i;
            armed_q <= armed_q | key_n_i;
        end
    end

    assign press_o = armed_q & prev_q & ~key_n_i;

endmodule

// File: rtl/bcd_field_counter.sv
// One BCD calendar/clock field: advances on tick_in in run mode, per-digit
// plus/minus editing in edit mode, clamps to a shrinking runtime max_val.
module bcd_field_counter
    import calendar_pkg::*;
#(
    parameter int unsigned               NUM_DIGITS = 2,
    parameter logic [4*NUM_DIGITS-1:0]   MIN_VAL    = 'h01,
    parameter logic [4*NUM_DIGITS-1:0]   RESET_VAL  = 'h01,
    parameter logic [1:0]                SCREEN_ID  = 2'd1,
    parameter logic [2:0]                POS_LSD    = 3'd3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick_in,
    input  logic                      key_plus,
    input  logic                      key_minus,
    input  logic                      edit_mode,
    input  logic [2:0]                edit_pos,
    input  logic [1:0]                screen,
    input  logic [4*NUM_DIGITS-1:0]   max_val,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic                      carry_out
);

    localparam int unsigned W = 4 * NUM_DIGITS;

    logic             plus_press;
    logic             minus_press;
    logic [W-1:0]     value_q;
    logic [W-1:0]     value_d;
    logic             carry_q;
    logic             carry_d;
    logic [MAX_W-1:0] inc_full;
    logic [W-1:0]     value_inc;
    logic             edit_en;
    logic [W-1:0]     plus_r;
    logic [W-1:0]     minus_r;
    logic             do_tick;
    logic             do_plus;
    logic             do_minus;

    key_edge_detect u_plus_edge (
        .clk_i   (clk),
        .reset_i (reset),
        .key_n_i (key_plus),
        .press_o (plus_press)
    );

    key_edge_detect u_minus_edge (
        .clk_i   (clk),
        .reset_i (reset),
        .key_n_i (key_minus),
        .press_o (minus_press)
    );

    always_comb begin
        inc_full = bcd_inc(MAX_W'(value_q), NUM_DIGITS);
    end

    assign value_inc = inc_full[W-1:0];

    // Digit k sits under the cursor when edit_pos == POS_LSD - k.
    always_comb begin
        edit_en = 1'b0;
        plus_r  = value_q;
        minus_r = value_q;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if ((k <= 32'(POS_LSD)) && (32'(edit_pos) == (32'(POS_LSD) - k))) begin
                edit_en              = (screen == SCREEN_ID);
                plus_r[4*k +: 4]     = digit_inc(value_q[4*k +: 4]);
                minus_r[4*k +: 4]    = digit_dec(value_q[4*k +: 4]);
            end
        end
    end

    assign do_tick  = ~edit_mode & tick_in;
    assign do_plus  = edit_mode & edit_en & plus_press;
    assign do_minus = edit_mode & edit_en & minus_press;

    always_comb begin
        value_d = value_q;
        carry_d = 1'b0;
        if (do_tick) begin
            if (value_q >= max_val) begin
                value_d = MIN_VAL;
                carry_d = 1'b1;
            end else begin
                value_d = value_inc;
            end
        end else if (do_plus) begin
            value_d = ((plus_r < MIN_VAL) || (plus_r > max_val)) ? MIN_VAL : plus_r;
        end else if (do_minus) begin
            value_d = ((minus_r < MIN_VAL) || (minus_r > max_val)) ? max_val : minus_r;
        end else if (value_q > max_val) begin
            value_d = max_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RESET_VAL;
            carry_q <= 1'b0;
        end else begin
            value_q <= value_d;
            carry_q <= carry_d;
        end
    end

    assign value     = value_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Directed table-driven bench for bcd_field_counter (2 digits, MIN 01, screen 1, LSD at pos 3).
module tb_bcd_field_counter;

    typedef struct {
        logic       rst;
        logic       tick;
        logic       kp;
        logic       km;
        logic       em;
        logic [2:0] pos;
        logic [1:0] scr;
        logic [7:0] maxv;
        logic [7:0] expv;
        logic       expc;
    } vec_t;

    vec_t vecs[$];

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_in;
    logic       key_plus;
    logic       key_minus;
    logic       edit_mode;
    logic [2:0] edit_pos;
    logic [1:0] screen;
    logic [7:0] max_val;
    logic [7:0] value;
    logic       carry_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_field_counter #(
        .NUM_DIGITS (2),
        .MIN_VAL    (8'h01),
        .RESET_VAL  (8'h01),
        .SCREEN_ID  (2'd1),
        .POS_LSD    (3'd3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .key_plus  (key_plus),
        .key_minus (key_minus),
        .edit_mode (edit_mode),
        .edit_pos  (edit_pos),
        .screen    (screen),
        .max_val   (max_val),
        .value     (value),
        .carry_out (carry_out)
    );

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic row(input logic rst, input logic tick, input logic kp, input logic km,
                       input logic em, input logic [2:0] pos, input logic [1:0] scr,
                       input logic [7:0] maxv, input logic [7:0] expv, input logic expc);
        vec_t v;
        v.rst = rst; v.tick = tick; v.kp = kp; v.km = km; v.em = em;
        v.pos = pos; v.scr = scr; v.maxv = maxv; v.expv = expv; v.expc = expc;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        @(negedge clk);
        reset     = v.rst;
        tick_in   = v.tick;
        key_plus  = v.kp;
        key_minus = v.km;
        edit_mode = v.em;
        edit_pos  = v.pos;
        screen    = v.scr;
        max_val   = v.maxv;
        @(posedge clk);
        #1;
        checks++;
        if (value !== v.expv) begin
            errors++;
            $display("FAIL %s[%0d] value: got %h expected %h", tag, idx, value, v.expv);
        end
        checks++;
        if (carry_out !== v.expc) begin
            errors++;
            $display("FAIL %s[%0d] carry_out: got %b expected %b", tag, idx, carry_out, v.expc);
        end
    endtask

    initial begin
        reset = 1'b1; tick_in = 1'b0; key_plus = 1'b1; key_minus = 1'b1;
        edit_mode = 1'b0; edit_pos = 3'd3; screen = 2'd1; max_val = 8'h12;

        // reset, then run counting 01..12 and wrap with one-cycle carry
        row(1, 0, 1, 1, 0, 3, 1, 8'h12, 8'h01, 0);
        row(1, 0, 1, 1, 0, 3, 1, 8'h12, 8'h01, 0);
        for (int i = 1; i <= 10; i++) row(0, 1, 1, 1, 0, 3, 1, 8'h12, bcd(i + 1), 0);
        row(0, 1, 1, 1, 0, 3, 1, 8'h12, 8'h12, 0);
        row(0, 1, 1, 1, 0, 3, 1, 8'h12, 8'h01, 1);
        row(0, 0, 1, 1, 0, 3, 1, 8'h12, 8'h01, 0);
        for (int i = 1; i <= 8; i++) row(0, 1, 1, 1, 0, 3, 1, 8'h12, bcd(i + 1), 0);
        // digit edits with out-of-range fixups
        row(0, 0, 1, 1, 1, 3, 1, 8'h12, 8'h09, 0);
        row(0, 0, 0, 1, 1, 3, 1, 8'h12, 8'h01, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h12, 8'h01, 0);
        row(0, 0, 1, 0, 1, 3, 1, 8'h12, 8'h12, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h12, 8'h12, 0);
        row(0, 1, 1, 1, 0, 3, 1, 8'h12, 8'h01, 1);
        for (int i = 1; i <= 4; i++) row(0, 1, 1, 1, 0, 3, 1, 8'h12, bcd(i + 1), 0);
        row(0, 0, 0, 1, 1, 2, 1, 8'h12, 8'h01, 0);
        row(0, 0, 1, 1, 1, 2, 1, 8'h12, 8'h01, 0);
        row(0, 0, 0, 1, 1, 2, 1, 8'h12, 8'h11, 0);
        row(0, 0, 1, 1, 1, 2, 1, 8'h12, 8'h11, 0);
        row(0, 0, 1, 0, 1, 2, 1, 8'h12, 8'h01, 0);
        row(0, 0, 1, 1, 1, 2, 1, 8'h12, 8'h01, 0);
        row(0, 0, 0, 1, 1, 3, 1, 8'h12, 8'h02, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h12, 8'h02, 0);
        // gating: wrong screen, cursor off-field, tick in edit mode
        row(0, 0, 0, 1, 1, 3, 2, 8'h12, 8'h02, 0);
        row(0, 0, 1, 1, 1, 3, 2, 8'h12, 8'h02, 0);
        row(0, 0, 1, 0, 1, 5, 1, 8'h12, 8'h02, 0);
        row(0, 0, 1, 1, 1, 5, 1, 8'h12, 8'h02, 0);
        row(0, 0, 0, 1, 1, 1, 1, 8'h12, 8'h02, 0);
        row(0, 0, 1, 1, 1, 1, 1, 8'h12, 8'h02, 0);
        row(0, 1, 1, 1, 1, 3, 1, 8'h12, 8'h02, 0);
        // both keys together; held minus gives no late action; tick beats press
        row(0, 0, 0, 0, 1, 3, 1, 8'h12, 8'h03, 0);
        row(0, 0, 1, 0, 1, 3, 1, 8'h12, 8'h03, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h12, 8'h03, 0);
        row(0, 1, 0, 1, 0, 3, 1, 8'h12, 8'h04, 0);
        row(0, 0, 1, 1, 0, 3, 1, 8'h12, 8'h04, 0);
        row(0, 0, 1, 0, 0, 3, 1, 8'h12, 8'h04, 0);
        row(0, 0, 1, 1, 0, 3, 1, 8'h12, 8'h04, 0);
        // clamp when max shrinks; tick in edit mode at max keeps carry low
        row(0, 0, 1, 0, 1, 2, 1, 8'h31, 8'h31, 0);
        row(0, 0, 1, 1, 1, 2, 1, 8'h31, 8'h31, 0);
        row(0, 0, 1, 0, 1, 3, 1, 8'h31, 8'h30, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h31, 8'h30, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h28, 8'h28, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h28, 8'h28, 0);
        row(0, 1, 1, 1, 1, 3, 1, 8'h28, 8'h28, 0);
        row(0, 0, 0, 1, 1, 3, 1, 8'h31, 8'h29, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h31, 8'h29, 0);
        row(0, 0, 0, 1, 1, 3, 1, 8'h31, 8'h20, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h31, 8'h20, 0);
        row(0, 0, 0, 1, 1, 2, 1, 8'h31, 8'h30, 0);
        row(0, 0, 1, 1, 1, 2, 1, 8'h31, 8'h30, 0);
        row(0, 1, 1, 1, 0, 3, 1, 8'h28, 8'h01, 1);
        row(0, 0, 1, 1, 0, 3, 1, 8'h28, 8'h01, 0);

        foreach (vecs[i]) apply(vecs[i], "table", i);

        // key held low across reset release must not act; a fresh press must
        vecs.delete();
        row(1, 0, 0, 1, 1, 3, 1, 8'h12, 8'h01, 0);
        row(1, 0, 0, 1, 1, 3, 1, 8'h12, 8'h01, 0);
        row(0, 0, 0, 1, 1, 3, 1, 8'h12, 8'h01, 0);
        row(0, 0, 0, 1, 1, 3, 1, 8'h12, 8'h01, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h12, 8'h01, 0);
        row(0, 0, 0, 1, 1, 3, 1, 8'h12, 8'h02, 0);
        row(0, 0, 1, 1, 1, 3, 1, 8'h12, 8'h02, 0);
        foreach (vecs[i]) apply(vecs[i], "held_reset", i);

        // run-mode clamp without tick, then wrap from value == max == MIN
        vecs.delete();
        row(0, 0, 1, 1, 0, 3, 1, 8'h01, 8'h01, 0);
        row(0, 1, 1, 1, 0, 3, 1, 8'h01, 8'h01, 1);
        row(0, 1, 1, 1, 0, 3, 1, 8'h12, 8'h02, 0);
        foreach (vecs[i]) apply(vecs[i], "run_clamp", i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
